// File: rtl/iddr_deser.sv
// iddr_deser: DDR input capture and deserializer.
// Samples D on both edges of C and presents the rise/fall pair on Q0/Q1.
// Successive pairs are packed into WIDTH-bit words, and each finished word
// is flagged by a one-cycle WORD_VALID strobe. A BITSLIP request moves the
// word boundary one pair later.
// Ports:
//   C          clock; D is sampled on both edges
//   R_N        asynchronous active-low reset
//   CE         clock enable, sampled on the rise of C
//   D          DDR serial data
//   BITSLIP    slip request, sampled on the rise of C
//   Q0/Q1      rise/fall bit pair (timing set by DDR_ALIGNMENT)
//   WORD       last completed word
//   WORD_VALID one-cycle strobe marking a WORD update
//   SLIP_BUSY  high from an accepted slip through the guard window
module iddr_deser #(
   parameter int unsigned DDR_ALIGNMENT = 1,
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned MSB_FIRST     = 1,
   parameter int unsigned SLIP_GUARD    = 2
) (
   input  logic             C,
   input  logic             R_N,
   input  logic             CE,
   input  logic             D,
   input  logic             BITSLIP,
   output logic             Q0,
   output logic             Q1,
   output logic [WIDTH-1:0] WORD,
   output logic             WORD_VALID,
   output logic             SLIP_BUSY
);

   localparam int unsigned NPAIR = WIDTH / 2;
   localparam int unsigned CW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam int unsigned GW    = (SLIP_GUARD > 1) ? $clog2(SLIP_GUARD) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SLIP  = 2'd1,
      GUARD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [GW-1:0]    guard_q, guard_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             d_pos_q, d_pos_d;
   logic             d_neg_q, d_neg_d;
   logic             ce_q, ce_d;
   logic             cap_vld_q, cap_vld_d;
   logic             pair_rise_q, pair_rise_d;
   logic             pair_fall_q, pair_fall_d;
   logic             pair_vld_q, pair_vld_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             word_valid_q, word_valid_d;
   logic             slip_busy_q, slip_busy_d;
   logic             slip_take;
   logic [WIDTH-1:0] sr_shift;

   // Next-state for the rise domain: capture, alignment, packing and the slip FSM
   always_comb begin
      state_d      = state_q;
      guard_d      = guard_q;
      cnt_d        = cnt_q;
      d_pos_d      = d_pos_q;
      ce_d         = CE;
      cap_vld_d    = cap_vld_q;
      pair_rise_d  = pair_rise_q;
      pair_fall_d  = pair_fall_q;
      pair_vld_d   = pair_vld_q;
      sr_d         = sr_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      slip_busy_d  = slip_busy_q;
      slip_take    = 1'b0;

      // Rise bit enters ahead of the fall bit in both packing orders
      if (MSB_FIRST != 0)
         sr_shift = (sr_q << 2) | WIDTH'({pair_rise_q, pair_fall_q});
      else
         sr_shift = (sr_q >> 2) | (WIDTH'({pair_fall_q, pair_rise_q}) << (WIDTH - 2));

      if (CE) begin
         d_pos_d     = D;
         cap_vld_d   = 1'b1;
         pair_rise_d = d_pos_q;
         pair_fall_d = d_neg_q;
         pair_vld_d  = cap_vld_q;

         case (state_q)
            IDLE: begin
               if (BITSLIP) begin
                  state_d   = SLIP;
                  slip_take = 1'b1;
               end
            end
            SLIP: begin
               state_d = GUARD;
               guard_d = '0;
            end
            GUARD: begin
               if (guard_q == GW'(SLIP_GUARD - 1))
                  state_d = IDLE;
               else
                  guard_d = guard_q + GW'(1);
            end
            default: state_d = IDLE;
         endcase

         // An accepted slip drops the pair due this rise and holds the count
         if (pair_vld_q && !slip_take) begin
            sr_d = sr_shift;
            if (cnt_q == CW'(NPAIR - 1)) begin
               cnt_d        = '0;
               word_d       = sr_shift;
               word_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         slip_busy_d = (state_d != IDLE);
      end
   end

   // Rise-domain registers
   always_ff @(posedge C or negedge R_N) begin
      if (!R_N) begin
         state_q      <= IDLE;
         guard_q      <= '0;
         cnt_q        <= '0;
         d_pos_q      <= 1'b0;
         ce_q         <= 1'b0;
         cap_vld_q    <= 1'b0;
         pair_rise_q  <= 1'b0;
         pair_fall_q  <= 1'b0;
         pair_vld_q   <= 1'b0;
         sr_q         <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         slip_busy_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         guard_q      <= guard_d;
         cnt_q        <= cnt_d;
         d_pos_q      <= d_pos_d;
         ce_q         <= ce_d;
         cap_vld_q    <= cap_vld_d;
         pair_rise_q  <= pair_rise_d;
         pair_fall_q  <= pair_fall_d;
         pair_vld_q   <= pair_vld_d;
         sr_q         <= sr_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         slip_busy_q  <= slip_busy_d;
      end
   end

   // The fall capture is skipped when CE was low at the preceding rise
   always_comb d_neg_d = ce_q ? D : d_neg_q;

   always_ff @(negedge C or negedge R_N) begin
      if (!R_N) d_neg_q <= 1'b0;
      else      d_neg_q <= d_neg_d;
   end

   assign Q0         = (DDR_ALIGNMENT != 0) ? pair_rise_q : d_pos_q;
   assign Q1         = (DDR_ALIGNMENT != 0) ? pair_fall_q : d_neg_q;
   assign WORD       = word_q;
   assign WORD_VALID = word_valid_q;
   assign SLIP_BUSY  = slip_busy_q;

endmodule

// File: tb/tb_iddr_deser.sv
// tb_iddr_deser: directed bench for iddr_deser.
// Three instances share the stimulus: the default build, an LSB-first build
// and a DDR_ALIGNMENT=0 build.
module tb_iddr_deser;

   logic       C, R_N, CE, D, BITSLIP;
   logic       q0_a1, q1_a1, wv_a1, busy_a1;
   logic [7:0] word_a1;
   logic       q0_lsb, q1_lsb, wv_lsb, busy_lsb;
   logic [7:0] word_lsb;
   logic       q0_a0, q1_a0, wv_a0, busy_a0;
   logic [7:0] word_a0;

   int n_checks = 0;
   int n_errors = 0;

   // Outputs captured 1 ns after the rise, before the following fall
   logic s_q0_a1, s_q1_a1, s_q0_a0, s_q1_a0;

   iddr_deser #(.DDR_ALIGNMENT(1), .WIDTH(8), .MSB_FIRST(1), .SLIP_GUARD(2)) u_dut (
      .C(C), .R_N(R_N), .CE(CE), .D(D), .BITSLIP(BITSLIP),
      .Q0(q0_a1), .Q1(q1_a1), .WORD(word_a1), .WORD_VALID(wv_a1), .SLIP_BUSY(busy_a1));

   iddr_deser #(.DDR_ALIGNMENT(1), .WIDTH(8), .MSB_FIRST(0), .SLIP_GUARD(2)) u_lsb (
      .C(C), .R_N(R_N), .CE(CE), .D(D), .BITSLIP(BITSLIP),
      .Q0(q0_lsb), .Q1(q1_lsb), .WORD(word_lsb), .WORD_VALID(wv_lsb), .SLIP_BUSY(busy_lsb));

   iddr_deser #(.DDR_ALIGNMENT(0), .WIDTH(8), .MSB_FIRST(1), .SLIP_GUARD(2)) u_a0 (
      .C(C), .R_N(R_N), .CE(CE), .D(D), .BITSLIP(BITSLIP),
      .Q0(q0_a0), .Q1(q1_a0), .WORD(word_a0), .WORD_VALID(wv_a0), .SLIP_BUSY(busy_a0));

   initial C = 1'b0;
   always #5 C = ~C;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: inputs set just after a fall, rise bit then fall bit on D
   task automatic step(input logic ce, input logic slip, input logic rb, input logic fb);
      CE = ce; BITSLIP = slip; D = rb;
      @(posedge C); #1;
      s_q0_a1 = q0_a1; s_q1_a1 = q1_a1; s_q0_a0 = q0_a0; s_q1_a0 = q1_a0;
      D = fb; BITSLIP = 1'b0;
      @(negedge C); #1;
   endtask

   // Asynchronous reset pulse between edges, with immediate output checks
   task automatic async_reset(input string nm);
      CE = 1'b0; BITSLIP = 1'b0;
      #2 R_N = 1'b0;
      #1;
      chk({nm, "_q0"},   q0_a1,   1'b0);
      chk({nm, "_q1"},   q1_a1,   1'b0);
      chk({nm, "_word"}, word_a1, 8'h00);
      chk({nm, "_wv"},   wv_a1,   1'b0);
      chk({nm, "_busy"}, busy_a1, 1'b0);
      chk({nm, "_a0q0"}, q0_a0,   1'b0);
      chk({nm, "_a0q1"}, q1_a0,   1'b0);
      chk({nm, "_lsbw"}, word_lsb, 8'h00);
      R_N = 1'b1;
      @(negedge C); #1;
   endtask

   typedef struct {
      logic       ce, slip, rb, fb;
      logic       wv;
      logic [7:0] word, word_lsb;
      logic       busy;
   } vec_t;

   vec_t tbl[19];
   // 8'hB2 as rise/fall pairs: (1,0) (1,1) (0,0) (1,0)
   logic [3:0] pr;
   logic [3:0] pf;
   logic [7:0] pb0, pb1;

   initial begin
      pr = 4'b1011;
      pf = 4'b0010;
      // Repeating B2 stream, slip at rise 6, ignored second slip at rise 8.
      // The slip drops pair 4, so later words are pairs 5..8 etc: MSB CA, LSB 53.
      for (int r = 0; r < 19; r++) begin
         tbl[r].ce       = 1'b1;
         tbl[r].rb       = pr[r % 4];
         tbl[r].fb       = pf[r % 4];
         tbl[r].slip     = (r == 6 || r == 8);
         tbl[r].wv       = (r == 5 || r == 10 || r == 14 || r == 18);
         tbl[r].word     = (r < 5) ? 8'h00 : (r < 10) ? 8'hB2 : 8'hCA;
         tbl[r].word_lsb = (r < 5) ? 8'h00 : (r < 10) ? 8'h4D : 8'h53;
         tbl[r].busy     = (r >= 6 && r <= 8);
      end

      R_N = 1'b0; CE = 1'b0; D = 1'b0; BITSLIP = 1'b0;
      @(negedge C); #1;
      chk("rst_word", word_a1, 8'h00);
      chk("rst_wv",   wv_a1,   1'b0);
      R_N = 1'b1;

      for (int r = 0; r < 19; r++) begin
         step(tbl[r].ce, tbl[r].slip, tbl[r].rb, tbl[r].fb);
         chk($sformatf("row%0d_wv", r),    wv_a1,    tbl[r].wv);
         chk($sformatf("row%0d_word", r),  word_a1,  tbl[r].word);
         chk($sformatf("row%0d_busy", r),  busy_a1,  tbl[r].busy);
         chk($sformatf("row%0d_lwv", r),   wv_lsb,   tbl[r].wv);
         chk($sformatf("row%0d_lword", r), word_lsb, tbl[r].word_lsb);
         pb0 = (r == 0) ? 8'd0 : 8'(tbl[r-1].rb);
         pb1 = (r == 0) ? 8'd0 : 8'(tbl[r-1].fb);
         chk($sformatf("row%0d_a1q0", r), q0_a1, pb0[0]);
         chk($sformatf("row%0d_a1q1", r), q1_a1, pb1[0]);
         chk($sformatf("row%0d_a0q0", r), q0_a0, tbl[r].rb);
         chk($sformatf("row%0d_a0q1", r), q1_a0, tbl[r].fb);
      end

      // CE low for three rises after pair 1: outputs frozen, word 3 rises late
      async_reset("rstA");
      step(1, 0, 1, 0);
      step(1, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         chk($sformatf("ce%0d_wv", i),   wv_a1, 1'b0);
         chk($sformatf("ce%0d_a1q0", i), q0_a1, 1'b1);
         chk($sformatf("ce%0d_a1q1", i), q1_a1, 1'b0);
         chk($sformatf("ce%0d_a0q0", i), q0_a0, 1'b1);
         chk($sformatf("ce%0d_a0q1", i), q1_a0, 1'b1);
      end
      step(1, 0, 0, 0);
      chk("ce_r2_wv", wv_a1, 1'b0);
      step(1, 0, 1, 0);
      chk("ce_r3_wv", wv_a1, 1'b0);
      step(1, 0, 1, 0);
      chk("ce_r4_wv", wv_a1, 1'b0);
      chk("ce_r4_word", word_a1, 8'h00);
      step(1, 0, 1, 1);
      chk("ce_r5_wv",   wv_a1,    1'b1);
      chk("ce_r5_word", word_a1,  8'hB2);
      chk("ce_r5_lsbw", word_lsb, 8'h4D);

      // Two more pairs, then async reset mid-word; new word has no residue
      step(1, 0, 1, 1);
      step(1, 0, 1, 1);
      chk("pre_rst_q0", q0_a1, 1'b1);
      async_reset("rstB");
      // Slip before the first valid pair leaves the boundary unchanged
      for (int r = 0; r < 6; r++) begin
         step(1, (r == 0), pr[r % 4], pf[r % 4]);
         chk($sformatf("rb%0d_busy", r), busy_a1, (r <= 2));
         chk($sformatf("rb%0d_wv", r),   wv_a1,   (r == 5));
         chk($sformatf("rb%0d_word", r), word_a1, (r == 5) ? 8'hB2 : 8'h00);
      end

      // DDR_ALIGNMENT timing: a0 follows each edge, a1 lags by one rise
      async_reset("rstC");
      step(1, 0, 0, 1);
      chk("al_c0_a0q0", q0_a0, 1'b0);
      chk("al_c0_a0q1", q1_a0, 1'b1);
      step(1, 0, 1, 0);
      chk("al_c1r_a0q0", s_q0_a0, 1'b1);
      chk("al_c1r_a0q1", s_q1_a0, 1'b1);
      chk("al_c1r_a1q0", s_q0_a1, 1'b0);
      chk("al_c1r_a1q1", s_q1_a1, 1'b1);
      chk("al_c1f_a0q1", q1_a0,   1'b0);
      step(1, 0, 0, 0);
      chk("al_c2r_a1q0", s_q0_a1, 1'b1);
      chk("al_c2r_a1q1", s_q1_a1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
